// File: rtl/im_loader.sv
// im_loader: boot-time writer for the instruction memory.
//
// The loader takes a byte stream over a valid/ready handshake. The stream
// starts with a 2-byte big-endian word count and is followed by the payload
// words, each sent big-endian. Every assembled 32-bit word goes to the IM
// write port. The CPU core is held in reset until a load completes.
//
// Build option: define IM_LOADER_CHECKSUM_EN to require a trailing
// modulo-256 checksum byte over the payload. When it is defined, a mismatch
// ends the load in ERR.
//
// Parameters:
//   ADDR_W     IM word-address width; capacity is 2^ADDR_W words
//   BASE_ADDR  byte address of the first written word (word aligned)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      single-cycle pulse; begins a load from IDLE, DONE or ERR
//   rx_data    stream byte
//   rx_valid   rx_data valid
//   rx_ready   loader accepts a byte this cycle (state-only)
//   im_we      IM write strobe, one cycle per word
//   im_waddr   IM byte address = BASE_ADDR + 4*word_index
//   im_wdata   assembled instruction
//   cpu_rst_n  active-low CPU reset; high only in DONE
//   busy       high while a load is in progress
//   done       high in DONE
//   err        high in ERR
//
// state  | meaning
// -------+----------------------------------------------------
// IDLE   | after reset, waiting for start
// LEN_HI | expecting word-count high byte
// LEN_LO | expecting word-count low byte; length checked here
// DATA   | receiving payload bytes, one IM write per 4 bytes
// CSUM   | expecting checksum byte (checksum build only)
// DONE   | image loaded, CPU released
// ERR    | oversize length or checksum mismatch, CPU held
module im_loader #(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        im_we,
    output logic [31:0] im_waddr,
    output logic [31:0] im_wdata,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
`ifdef IM_LOADER_CHECKSUM_EN
        S_CSUM   = 3'd4,
`endif
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    // State that follows the payload (or a zero length).
`ifdef IM_LOADER_CHECKSUM_EN
    localparam state_t S_POST = S_CSUM;
`else
    localparam state_t S_POST = S_DONE;
`endif

    localparam logic [31:0] CAPACITY = 32'd1 << ADDR_W;

    state_t            state;
    state_t            state_nxt;
    logic [15:0]       len;
    logic [ADDR_W:0]   idx;
    logic [ADDR_W:0]   idx_inc;
    logic [1:0]        lane;
    logic [23:0]       shreg;
    logic [15:0]       len_full;
    logic              xfer;
    logic              last_word;
    logic              load_begin;
`ifdef IM_LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    // Status outputs and rx_ready depend on the state only.
`ifdef IM_LOADER_CHECKSUM_EN
    assign busy = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                  (state == S_DATA)   || (state == S_CSUM);
`else
    assign busy = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                  (state == S_DATA);
`endif
    assign rx_ready = busy;
    assign done     = (state == S_DONE);
    assign err      = (state == S_ERR);

    assign xfer      = rx_valid && busy;
    assign len_full  = {len[15:8], rx_data};
    assign idx_inc   = idx + (ADDR_W+1)'(1);
    assign last_word = (32'(idx_inc) == 32'(len));
    assign load_begin = (state != S_LEN_HI) && (state_nxt == S_LEN_HI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (xfer) state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (xfer) begin
                    if (len_full == 16'd0)
                        state_nxt = S_POST;
                    else if (32'(len_full) > CAPACITY)
                        state_nxt = S_ERR;
                    else
                        state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer && (lane == 2'd3) && last_word) state_nxt = S_POST;
            end
`ifdef IM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (xfer) state_nxt = (rx_data == csum) ? S_DONE : S_ERR;
            end
`endif
            S_DONE, S_ERR: begin
                if (start) state_nxt = S_LEN_HI;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len       <= '0;
            idx       <= '0;
            lane      <= '0;
            shreg     <= '0;
            im_we     <= 1'b0;
            im_waddr  <= BASE_ADDR;
            im_wdata  <= '0;
            cpu_rst_n <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            im_we     <= 1'b0;
            // The CPU runs only while the loader sits in DONE.
            cpu_rst_n <= (state_nxt == S_DONE);

            if (load_begin) begin
                len  <= '0;
                idx  <= '0;
                lane <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
                csum <= '0;
`endif
            end

            if (xfer) begin
                case (state)
                    S_LEN_HI: len[15:8] <= rx_data;
                    S_LEN_LO: len[7:0]  <= rx_data;
                    S_DATA: begin
                        shreg <= {shreg[15:0], rx_data};
                        lane  <= lane + 2'd1;
`ifdef IM_LOADER_CHECKSUM_EN
                        csum  <= csum + rx_data;
`endif
                        // The 4th byte completes the word. The write is
                        // presented on the next cycle while the stream
                        // keeps flowing.
                        if (lane == 2'd3) begin
                            im_we    <= 1'b1;
                            im_wdata <= {shreg, rx_data};
                            im_waddr <= BASE_ADDR + (32'(idx) << 2);
                            idx      <= idx_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_im_loader.sv
`timescale 1ns/1ps
module tb_im_loader;

    localparam int          ADDR_W = 8;
    localparam logic [31:0] BASE   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        im_we;
    logic [31:0] im_waddr;
    logic [31:0] im_wdata;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    im_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
        .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        string       name;
        logic [15:0] len;
        int          nsend;
        bit          gaps;
        bit          csum_bad;
        bit          exp_err;
        logic [31:0] w0;
        logic [31:0] w1;
    } case_t;

    wr_t         exp_q[$];
    wr_t         exp_e;
    case_t       cases[$];
    int          checks   = 0;
    int          errors   = 0;
    int          n_writes = 0;
    logic [31:0] last_waddr = '0;
    logic        prev_we  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Write monitor: pops the scoreboard on every IM write strobe.
    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            n_writes++;
            last_waddr = im_waddr;
            chk1("im_we single-cycle", prev_we, 1'b0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write",
                         im_waddr, im_wdata);
            end else begin
                exp_e = exp_q.pop_front();
                chk("im_waddr", im_waddr, exp_e.addr);
                chk("im_wdata", im_wdata, exp_e.data);
            end
        end
        prev_we = im_we;
    end

    function automatic logic [31:0] word_of(input case_t c, input int i);
        logic [7:0] k;
        k = 8'(i);
        if (i == 0) return c.w0;
        if (i == 1) return c.w1;
        return {k, ~k, 8'hA5, k ^ 8'h3C};
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        bit ok;
        n = 0;
        if (gap) begin
            rx_valid = 1'b0;
            @(posedge clk); #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        forever begin
            ok = rx_ready;
            @(posedge clk); #1;
            if (ok) break;
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL send_byte_timeout: rx_ready got 0 expected 1");
                break;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int index, input bit gap,
                             inout logic [7:0] sum);
        wr_t e;
        for (int b = 0; b < 4; b++) begin
            sum = sum + w[31-8*b -: 8];
            if (b == 3) begin
                e.addr = BASE + 32'(index) * 32'd4;
                e.data = w;
                exp_q.push_back(e);
            end
            send_byte(w[31-8*b -: 8], gap);
        end
    endtask

    task automatic wait_end(input string name);
        int n;
        n = 0;
        while (!(done || err) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk1({name, " end reached"}, done | err, 1'b1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_case(input case_t c);
        int         w0;
        logic [7:0] sum;
        w0  = n_writes;
        sum = 8'h00;
        pulse_start();
        chk1({c.name, " busy"}, busy, 1'b1);
        chk1({c.name, " cpu_rst_n in load"}, cpu_rst_n, 1'b0);
        send_byte(c.len[15:8], c.gaps);
        send_byte(c.len[7:0], c.gaps);
        for (int i = 0; i < c.nsend; i++)
            send_word(word_of(c, i), i, c.gaps, sum);
`ifdef IM_LOADER_CHECKSUM_EN
        if (c.len <= 16'd256)
            send_byte(c.csum_bad ? sum + 8'd1 : sum, c.gaps);
`endif
        wait_end(c.name);
        chk1({c.name, " done"}, done, !c.exp_err);
        chk1({c.name, " err"}, err, c.exp_err);
        chk1({c.name, " cpu_rst_n"}, cpu_rst_n, !c.exp_err);
        chk1({c.name, " rx_ready"}, rx_ready, 1'b0);
        chk1({c.name, " busy end"}, busy, 1'b0);
        chk({c.name, " write count"}, 32'(n_writes - w0), 32'(c.nsend));
        chk({c.name, " pending writes"}, 32'(exp_q.size()), 32'd0);
        if (c.nsend > 0)
            chk({c.name, " last waddr"}, last_waddr, BASE + 32'(c.nsend - 1) * 32'd4);
    endtask

    initial begin
        int          w0;
        logic [7:0]  sum;

        cases.push_back('{"two_word",  16'd2,   2,   1'b0, 1'b0, 1'b0, 32'h3C010010, 32'h8C220004});
        cases.push_back('{"gaps",      16'd2,   2,   1'b1, 1'b0, 1'b0, 32'h3C010010, 32'h8C220004});
        cases.push_back('{"oversize",  16'd257, 0,   1'b0, 1'b0, 1'b1, 32'h0,        32'h0});
        cases.push_back('{"after_err", 16'd1,   1,   1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0});
        cases.push_back('{"len_zero",  16'd0,   0,   1'b0, 1'b0, 1'b0, 32'h0,        32'h0});
        cases.push_back('{"full",      16'd256, 256, 1'b0, 1'b0, 1'b0, 32'h00112233, 32'h44556677});
`ifdef IM_LOADER_CHECKSUM_EN
        cases.push_back('{"csum_ok",   16'd1,   1,   1'b0, 1'b0, 1'b0, 32'h01020304, 32'h0});
        cases.push_back('{"csum_bad",  16'd1,   1,   1'b0, 1'b1, 1'b1, 32'h01020304, 32'h0});
`endif

        rst_n    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #12;
        chk1("reset rx_ready", rx_ready, 1'b0);
        chk1("reset im_we", im_we, 1'b0);
        chk("reset im_waddr", im_waddr, BASE);
        chk("reset im_wdata", im_wdata, 32'h0);
        chk1("reset cpu_rst_n", cpu_rst_n, 1'b0);
        chk1("reset busy", busy, 1'b0);
        chk1("reset done", done, 1'b0);
        chk1("reset err", err, 1'b0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // rx_valid in IDLE must not be taken.
        rx_valid = 1'b1;
        rx_data  = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        rx_valid = 1'b0;
        chk1("idle ignores rx busy", busy, 1'b0);
        chk("idle ignores rx writes", 32'(n_writes), 32'd0);

        for (int i = 0; i < cases.size(); i++)
            run_case(cases[i]);

        // rx_valid while in DONE or ERR is ignored.
        w0 = n_writes;
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        repeat (4) @(posedge clk);
        #1;
        rx_valid = 1'b0;
        chk("post-load no writes", 32'(n_writes - w0), 32'd0);
        chk1("post-load rx_ready", rx_ready, 1'b0);

        // Reset in the middle of the second word.
        w0  = n_writes;
        sum = 8'h00;
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_word(32'h3C010010, 0, 1'b0, sum);
        send_byte(8'h8C, 1'b0);
        rst_n = 1'b0;
        #1;
        chk1("midreset rx_ready", rx_ready, 1'b0);
        chk1("midreset im_we", im_we, 1'b0);
        chk("midreset im_waddr", im_waddr, BASE);
        chk("midreset im_wdata", im_wdata, 32'h0);
        chk1("midreset cpu_rst_n", cpu_rst_n, 1'b0);
        chk1("midreset busy", busy, 1'b0);
        chk1("midreset done", done, 1'b0);
        chk1("midreset err", err, 1'b0);
        chk("midreset write count", 32'(n_writes - w0), 32'd1);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reload from index 0; a start pulse in mid-load is ignored.
        w0  = n_writes;
        sum = 8'h00;
        pulse_start();
        send_byte(8'h00, 1'b0);
        pulse_start();
        chk1("start while busy", busy, 1'b1);
        send_byte(8'h01, 1'b0);
        send_word(32'h12345678, 0, 1'b0, sum);
`ifdef IM_LOADER_CHECKSUM_EN
        send_byte(sum, 1'b0);
`endif
        wait_end("reload");
        chk1("reload done", done, 1'b1);
        chk1("reload cpu_rst_n", cpu_rst_n, 1'b1);
        chk("reload write count", 32'(n_writes - w0), 32'd1);
        chk("reload waddr", last_waddr, BASE);
        chk("reload pending", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
